// File: rtl/frame_decimator.sv
// Merges DECIM frames of FRAME_LEN tagged samples bin by bin and drains one merged frame.
// Optional per-bin hit counters and out_hits port are enabled by defining FRAME_DECIM_HITS_EN.
module frame_decimator #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 80,
  parameter int DECIM     = 10,
  parameter int MODE      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef FRAME_DECIM_HITS_EN
  ,
  output logic [$clog2(DECIM+1)-1:0] out_hits
`endif
);

  localparam int BIN_W = $clog2(FRAME_LEN);
  localparam int FRM_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FRAME_LEN - 1);
  localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(DECIM - 1);

  typedef enum logic {COLLECT, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [BIN_W-1:0]     binCnt_q, binCnt_d;
  logic [FRM_W-1:0]     frmCnt_q, frmCnt_d;
  logic [BIN_W-1:0]     rdIdx_q, rdIdx_d;
  logic [FRAME_LEN-1:0] flag_q, flag_d;
  logic [DATA_W-1:0]    outData_q, outData_d;
  logic                 outValid_q, outValid_d;
  logic                 outLast_q, outLast_d;
  logic [DATA_W-1:0]    mem [FRAME_LEN];
  logic                 memWe;
  logic                 accept;
  logic                 tag;
  logic [BIN_W-1:0]     rdSel;
  logic [DATA_W-1:0]    binWord;

`ifdef FRAME_DECIM_HITS_EN
  localparam int HIT_W = $clog2(DECIM + 1);
  logic [HIT_W-1:0] hits_q [FRAME_LEN];
  logic [HIT_W-1:0] hits_d [FRAME_LEN];
  logic [HIT_W-1:0] outHits_q, outHits_d;
  assign out_hits = outHits_q;
`endif

  assign in_ready  = (state_q == COLLECT);
  assign accept    = in_valid && in_ready;
  assign tag       = in_data[DATA_W-1];
  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign out_last  = outLast_q;

  // Bin 0 is presented on entry to drain; afterwards the bin following the one on the port.
  assign rdSel   = (state_q == DRAIN && !outLast_q) ? BIN_W'(rdIdx_q + 1'b1) : '0;
  assign binWord = flag_q[rdSel] ? mem[rdSel] : '0;

  always_comb begin
    state_d    = state_q;
    binCnt_d   = binCnt_q;
    frmCnt_d   = frmCnt_q;
    rdIdx_d    = rdIdx_q;
    flag_d     = flag_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    outLast_d  = outLast_q;
    memWe      = 1'b0;
`ifdef FRAME_DECIM_HITS_EN
    hits_d    = hits_q;
    outHits_d = outHits_q;
`endif
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (tag) begin
            flag_d[binCnt_q] = 1'b1;
            memWe            = (MODE == 0) || !flag_q[binCnt_q];
`ifdef FRAME_DECIM_HITS_EN
            if (hits_q[binCnt_q] != '1) hits_d[binCnt_q] = hits_q[binCnt_q] + 1'b1;
`endif
          end
          if (binCnt_q == LAST_BIN) begin
            binCnt_d = '0;
            if (frmCnt_q == LAST_FRM) begin
              frmCnt_d   = '0;
              rdIdx_d    = '0;
              state_d    = DRAIN;
              outValid_d = 1'b1;
              outLast_d  = 1'b0;
              outData_d  = binWord;
`ifdef FRAME_DECIM_HITS_EN
              outHits_d = hits_q[0];
`endif
            end else begin
              frmCnt_d = frmCnt_q + 1'b1;
            end
          end else begin
            binCnt_d = binCnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (outLast_q) begin
            state_d    = COLLECT;
            outValid_d = 1'b0;
            outLast_d  = 1'b0;
            outData_d  = '0;
            flag_d     = '0;
            rdIdx_d    = '0;
`ifdef FRAME_DECIM_HITS_EN
            for (int i = 0; i < FRAME_LEN; i++) hits_d[i] = '0;
            outHits_d = '0;
`endif
          end else begin
            rdIdx_d   = rdSel;
            outData_d = binWord;
            outLast_d = (rdSel == LAST_BIN);
`ifdef FRAME_DECIM_HITS_EN
            outHits_d = hits_q[rdSel];
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= COLLECT;
      binCnt_q   <= '0;
      frmCnt_q   <= '0;
      rdIdx_q    <= '0;
      flag_q     <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
`ifdef FRAME_DECIM_HITS_EN
      for (int i = 0; i < FRAME_LEN; i++) hits_q[i] <= '0;
      outHits_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      binCnt_q   <= binCnt_d;
      frmCnt_q   <= frmCnt_d;
      rdIdx_q    <= rdIdx_d;
      flag_q     <= flag_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
`ifdef FRAME_DECIM_HITS_EN
      hits_q    <= hits_d;
      outHits_q <= outHits_d;
`endif
    end
  end

  // Sample memory is never reset; the flag vector decides whether a word is meaningful.
  always_ff @(posedge clk) begin
    if (memWe) mem[binCnt_q] <= in_data;
  end

endmodule

// File: tb/tb_frame_decimator.sv
// Randomised bench for frame_decimator: two 80x10 instances (latest/first-wins) on a shared
// stream plus a 4-bin pass-through instance, all checked against a window-level reference model.
module tb_frame_decimator;

  localparam int DW = 32;
  localparam int FL = 80;
  localparam int DC = 10;
  localparam int SL = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] inData;
  logic          inValid;
  logic          outReady;
  logic          inReady0, inReady1, outValid0, outValid1, outLast0, outLast1;
  logic [DW-1:0] outData0, outData1;
  logic [DW-1:0] sInData, sOutData;
  logic          sInValid, sInReady, sOutValid, sOutReady, sOutLast;
`ifdef FRAME_DECIM_HITS_EN
  logic [$clog2(DC+1)-1:0] outHits0, outHits1;
  logic                    sOutHits;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] win [DC][FL];
  logic [DW-1:0] sWin [SL];

  frame_decimator #(.DATA_W(DW), .FRAME_LEN(FL), .DECIM(DC), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inReady0),
    .out_data(outData0), .out_valid(outValid0), .out_ready(outReady), .out_last(outLast0)
`ifdef FRAME_DECIM_HITS_EN
    , .out_hits(outHits0)
`endif
  );

  frame_decimator #(.DATA_W(DW), .FRAME_LEN(FL), .DECIM(DC), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inReady1),
    .out_data(outData1), .out_valid(outValid1), .out_ready(outReady), .out_last(outLast1)
`ifdef FRAME_DECIM_HITS_EN
    , .out_hits(outHits1)
`endif
  );

  frame_decimator #(.DATA_W(DW), .FRAME_LEN(SL), .DECIM(1), .MODE(0)) dutS (
    .clk(clk), .rst(rst), .in_data(sInData), .in_valid(sInValid), .in_ready(sInReady),
    .out_data(sOutData), .out_valid(sOutValid), .out_ready(sOutReady), .out_last(sOutLast)
`ifdef FRAME_DECIM_HITS_EN
    , .out_hits(sOutHits)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan the window's frames for tagged samples in bin b.
  function automatic logic [DW-1:0] expBin(input int mode, input int b);
    logic [DW-1:0] r;
    bit found;
    r = '0;
    found = 0;
    for (int f = 0; f < DC; f++) begin
      if (win[f][b][DW-1]) begin
        if (mode == 0 || !found) r = win[f][b];
        found = 1;
      end
    end
    return r;
  endfunction

  function automatic int expHits(input int b);
    int n;
    n = 0;
    for (int f = 0; f < DC; f++) if (win[f][b][DW-1]) n++;
    return n;
  endfunction

  task automatic fillWindow(input int tagPct);
    logic [DW-1:0] d;
    for (int f = 0; f < DC; f++) begin
      for (int b = 0; b < FL; b++) begin
        d = $urandom;
        d[DW-1] = ($urandom_range(99) < tagPct);
        win[f][b] = d;
      end
    end
  endtask

  task automatic checkReset();
    checkOutput("rst out_valid", outValid0, 1'b0);
    checkOutput("rst out_last", outLast0, 1'b0);
    checkOutput("rst out_data", outData0, '0);
    checkOutput("rst in_ready", inReady0, 1'b1);
    checkOutput("rst out_valid m1", outValid1, 1'b0);
    checkOutput("rst out_valid small", sOutValid, 1'b0);
`ifdef FRAME_DECIM_HITS_EN
    checkOutput("rst out_hits", outHits0, '0);
`endif
  endtask

  task automatic applyStimulus(input int nSamples, input int gapPct);
    int n;
    n = 0;
    for (int f = 0; f < DC; f++) begin
      for (int b = 0; b < FL; b++) begin
        if (n < nSamples) begin
          while ($urandom_range(99) < gapPct) begin
            inValid = 1'b0;
            inData  = $urandom;
            tick();
          end
          checkOutput("collect in_ready", inReady0, 1'b1);
          inValid = 1'b1;
          inData  = win[f][b];
          tick();
          n++;
        end
      end
    end
    inValid = 1'b0;
  endtask

  // pattern: 0 = always ready, 1 = toggle every cycle, 2 = random
  task automatic drainCheck(input int pattern);
    int idx;
    int cyc;
    logic rdy;
    idx = 0;
    cyc = 0;
    while (idx < FL && cyc < 4 * FL) begin
      checkOutput("drain out_valid", outValid0, 1'b1);
      checkOutput($sformatf("drain m0 bin%0d", idx), outData0, expBin(0, idx));
      checkOutput($sformatf("drain m1 bin%0d", idx), outData1, expBin(1, idx));
      checkOutput("drain out_last", outLast0, (idx == FL - 1));
      checkOutput("drain in_ready", inReady0, 1'b0);
`ifdef FRAME_DECIM_HITS_EN
      checkOutput($sformatf("drain hits bin%0d", idx), outHits0, expHits(idx));
      checkOutput($sformatf("drain hits m1 bin%0d", idx), outHits1, expHits(idx));
`endif
      rdy      = (pattern == 0) ? 1'b1 : (pattern == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1));
      outReady = rdy;
      inValid  = 1'($urandom_range(1));
      inData   = $urandom | 32'h8000_0000;
      tick();
      if (rdy) idx++;
      cyc++;
    end
    checkOutput("drain completed", idx, FL);
    inValid  = 1'b0;
    outReady = 1'b0;
    checkOutput("post drain out_valid", outValid0, 1'b0);
    checkOutput("post drain out_last", outLast0, 1'b0);
    checkOutput("post drain in_ready", inReady0, 1'b1);
  endtask

  task automatic smallRun();
    int idx;
    int cyc;
    logic rdy;
    for (int b = 0; b < SL; b++) begin
      sInValid = 1'b1;
      sInData  = sWin[b];
      tick();
    end
    sInValid = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < SL && cyc < 100) begin
      checkOutput("small out_valid", sOutValid, 1'b1);
      checkOutput($sformatf("small bin%0d", idx), sOutData, sWin[idx][DW-1] ? sWin[idx] : '0);
      checkOutput("small out_last", sOutLast, (idx == SL - 1));
      checkOutput("small in_ready", sInReady, 1'b0);
`ifdef FRAME_DECIM_HITS_EN
      checkOutput("small hits", sOutHits, sWin[idx][DW-1]);
`endif
      rdy       = 1'($urandom_range(1));
      sOutReady = rdy;
      tick();
      if (rdy) idx++;
      cyc++;
    end
    checkOutput("small completed", idx, SL);
    sOutReady = 1'b0;
    checkOutput("small post out_valid", sOutValid, 1'b0);
    checkOutput("small post in_ready", sInReady, 1'b1);
  endtask

  initial begin
    rst       = 1'b0;
    inData    = '0;
    inValid   = 1'b0;
    outReady  = 1'b0;
    sInData   = '0;
    sInValid  = 1'b0;
    sOutReady = 1'b0;
    tick();
    tick();
    checkReset();
    rst = 1'b1;
    tick();

    $display("[TB] single tag in frame 3 bin 5");
    fillWindow(0);
    win[3][5] = 32'h8000_00AA;
    applyStimulus(DC * FL, 0);
    drainCheck(0);

    $display("[TB] latest vs first wins, toggled out_ready");
    fillWindow(0);
    win[0][7] = 32'h8000_0001;
    win[9][7] = 32'h8000_0002;
    applyStimulus(DC * FL, 10);
    drainCheck(1);

    $display("[TB] reset mid-window");
    fillWindow(30);
    applyStimulus(4 * FL + 40, 0);
    rst = 1'b0;
    tick();
    checkReset();
    rst = 1'b1;
    fillWindow(20);
    applyStimulus(DC * FL, 5);
    drainCheck(2);

    $display("[TB] bin 0 tagged in every frame");
    fillWindow(0);
    for (int f = 0; f < DC; f++) win[f][0] = $urandom | 32'h8000_0000;
    applyStimulus(DC * FL, 0);
    drainCheck(2);

    $display("[TB] random windows");
    for (int w = 0; w < 3; w++) begin
      fillWindow(15);
      applyStimulus(DC * FL, 20);
      drainCheck(2);
    end

    $display("[TB] pass-through instance");
    sWin[0] = 32'h8000_0001;
    sWin[1] = 32'h0000_0002;
    sWin[2] = 32'h8000_0003;
    sWin[3] = 32'h0000_0004;
    smallRun();
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < SL; b++) sWin[b] = $urandom;
      smallRun();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
